// File: rtl/tdm_pkg.sv
// Shared constants and types for the 8-lane TDM framer/deframer pair.
package tdm_pkg;

  localparam int unsigned NUM_SLOTS = 8;
  localparam int unsigned SLOT_W    = 3;

  // Lane index helpers
  localparam int unsigned      LAST_LANE  = NUM_SLOTS - 1;
  localparam logic [SLOT_W-1:0] FIRST_SLOT = SLOT_W'(0);
  localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(NUM_SLOTS - 1);

  typedef enum logic [0:0] {
    IDLE,
    RECV
  } tdm_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= '0;
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/tdm_demux8.sv
// TDM receive deframer: collects slots 0..7 into a shadow buffer and
// publishes them to eight parallel lanes only when a full frame has arrived.
module tdm_demux8
  import tdm_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           din,
  input  logic                       din_valid,
  input  logic                       frame_start,
  output logic [NUM_SLOTS*WIDTH-1:0] y,
  output logic                       frame_valid,
  output logic                       sync_err,
  output logic [CNT_W-1:0]           err_cnt
);

  tdm_state_t                          state_q, state_d;
  logic [SLOT_W-1:0]                   slot_q, slot_d;
  logic [NUM_SLOTS-1:0][WIDTH-1:0]     shadow_q;
  logic [NUM_SLOTS*WIDTH-1:0]          y_q;
  logic                                frame_valid_q;
  logic                                sync_err_q;

  logic                                wr_en;
  logic [SLOT_W-1:0]                   wr_idx;
  logic                                done;
  logic                                resync;
  logic [NUM_SLOTS*WIDTH-1:0]          frame_word;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    wr_en   = 1'b0;
    wr_idx  = slot_q;
    done    = 1'b0;
    resync  = 1'b0;
    if (din_valid) begin
      unique case (state_q)
        IDLE: begin
          // Samples before the first frame marker are discarded silently
          if (frame_start) begin
            wr_en   = 1'b1;
            wr_idx  = FIRST_SLOT;
            slot_d  = FIRST_SLOT + SLOT_W'(1);
            state_d = RECV;
          end
        end
        RECV: begin
          wr_en = 1'b1;
          if (frame_start) begin
            resync = 1'b1;
            wr_idx = FIRST_SLOT;
            slot_d = FIRST_SLOT + SLOT_W'(1);
          end else if (slot_q == LAST_SLOT) begin
            done    = 1'b1;
            slot_d  = FIRST_SLOT;
            state_d = IDLE;
          end else begin
            slot_d = slot_q + SLOT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // The last lane bypasses the shadow so y can load on the slot-7 edge.
  assign frame_word = {din, shadow_q[LAST_LANE-1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      slot_q        <= FIRST_SLOT;
      shadow_q      <= '0;
      y_q           <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      frame_valid_q <= done;
      sync_err_q    <= resync;
      if (wr_en) begin
        shadow_q[wr_idx] <= din;
      end
      if (done) begin
        y_q <= frame_word;
      end
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_err_cnt (
    .clk  (clk),
    .rst  (rst),
    .clear(1'b0),
    .inc  (resync),
    .count(err_cnt)
  );

  assign y           = y_q;
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_tdm_demux8.sv
// Scoreboard bench for tdm_demux8 (WIDTH=1, CNT_W=2): driver queues expected
// frames and error counts, a negedge monitor checks every output pulse.
module tb_tdm_demux8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [0:0] din = 1'b0;
  logic       din_valid = 1'b0;
  logic       frame_start = 1'b0;
  logic [7:0] y;
  logic       frame_valid;
  logic       sync_err;
  logic [1:0] err_cnt;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_q[$];
  logic [1:0] se_q[$];

  int cyc = 0;
  int fv_cyc = 0;
  int fv_cyc_prev = 0;

  always #5 clk = ~clk;

  tdm_demux8 #(
    .WIDTH(1),
    .CNT_W(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .frame_start(frame_start),
    .y          (y),
    .frame_valid(frame_valid),
    .sync_err   (sync_err),
    .err_cnt    (err_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: sample away from the active edge
  initial begin
    logic [7:0] y_prev = 8'h00;
    logic       prev_rst = 1'b1;
    logic       fv_prev = 1'b0;
    logic [7:0] e;
    logic [1:0] ec;
    forever begin
      @(negedge clk);
      cyc++;
      if (!prev_rst && (y !== y_prev) && !frame_valid) begin
        check("y_hold_between_frames", {24'h0, y}, {24'h0, y_prev});
      end
      if (frame_valid) begin
        check("fv_single_cycle", {31'h0, fv_prev}, 32'h0);
        check("fv_sync_err_exclusive", {31'h0, sync_err}, 32'h0);
        fv_cyc_prev = fv_cyc;
        fv_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("fv_unexpected", exp_q.size(), 32'h1);
        end else begin
          e = exp_q.pop_front();
          check("y_frame", {24'h0, y}, {24'h0, e});
        end
      end
      if (sync_err) begin
        if (se_q.size() == 0) begin
          check("sync_err_unexpected", se_q.size(), 32'h1);
        end else begin
          ec = se_q.pop_front();
          check("err_cnt_at_sync_err", {30'h0, err_cnt}, {30'h0, ec});
        end
      end
      y_prev = y;
      prev_rst = rst;
      fv_prev = frame_valid;
    end
  end

  task automatic drive_slot(input logic d, input logic fs, input int gap);
    din = d;
    din_valid = 1'b1;
    frame_start = fs;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    frame_start = 1'b0;
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
  endtask

  task automatic send_frame(input logic [7:0] f, input int gap);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) exp_q.push_back(f);
      drive_slot(f[i], (i == 0), gap);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic settle(input string name);
    repeat (3) @(posedge clk);
    #1;
    check(name, exp_q.size() + se_q.size(), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] sat_seq [5];
    sat_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    @(posedge clk);
    #1;

    // 1: reset state, then clean contiguous frame
    do_reset();
    check("reset_y", {24'h0, y}, 32'h0);
    check("reset_fv", {31'h0, frame_valid}, 32'h0);
    check("reset_se", {31'h0, sync_err}, 32'h0);
    check("reset_err_cnt", {30'h0, err_cnt}, 32'h0);
    send_frame(8'h4D, 0);
    settle("t1_drained");
    check("t1_y", {24'h0, y}, 32'h4D);

    // 2: gapped frame
    do_reset();
    send_frame(8'h4D, 1);
    settle("t2_drained");
    check("t2_y", {24'h0, y}, 32'h4D);

    // 3: resync after 3 slots, then all-ones frame
    do_reset();
    drive_slot(1'b1, 1'b1, 0);
    drive_slot(1'b0, 1'b0, 0);
    drive_slot(1'b1, 1'b0, 0);
    se_q.push_back(2'd1);
    send_frame(8'hFF, 0);
    settle("t3_drained");
    check("t3_err_cnt", {30'h0, err_cnt}, 32'h1);
    check("t3_y", {24'h0, y}, 32'hFF);

    // 4: junk before first frame marker
    do_reset();
    for (int i = 0; i < 5; i++) drive_slot(i[0], 1'b0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("t4_y_junk", {24'h0, y}, 32'h0);
    check("t4_err_cnt_junk", {30'h0, err_cnt}, 32'h0);
    send_frame(8'hC3, 0);
    settle("t4_drained");
    check("t4_y", {24'h0, y}, 32'hC3);

    // 5: back-to-back frames
    do_reset();
    send_frame(8'hA5, 0);
    send_frame(8'h3C, 0);
    settle("t5_drained");
    check("t5_fv_spacing", fv_cyc - fv_cyc_prev, 32'd8);
    check("t5_y", {24'h0, y}, 32'h3C);

    // 6: counter saturation, then reset mid-frame
    do_reset();
    send_frame(8'h5A, 0);
    drive_slot(1'b1, 1'b1, 0);
    for (int k = 0; k < 5; k++) begin
      drive_slot(1'b1, 1'b0, 0);
      se_q.push_back(sat_seq[k]);
      drive_slot(1'b0, 1'b1, 0);
    end
    drive_slot(1'b1, 1'b0, 0);
    drive_slot(1'b0, 1'b0, 0);
    drive_slot(1'b1, 1'b0, 0);
    check("t6_err_cnt_sat", {30'h0, err_cnt}, 32'h3);
    check("t6_y_before_rst", {24'h0, y}, 32'h5A);
    din = 1'b1;
    din_valid = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    din_valid = 1'b0;
    check("t6_rst_y", {24'h0, y}, 32'h0);
    check("t6_rst_fv", {31'h0, frame_valid}, 32'h0);
    check("t6_rst_se", {31'h0, sync_err}, 32'h0);
    check("t6_rst_err_cnt", {30'h0, err_cnt}, 32'h0);
    check("t6_se_drained", se_q.size(), 32'h0);
    send_frame(8'h81, 0);
    settle("t6_drained");
    check("t6_y", {24'h0, y}, 32'h81);
    check("t6_err_cnt_final", {30'h0, err_cnt}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
